// File: rtl/uart_pkg.sv
// Shared types and defaults for the buffered UART: one-hot frame FSM states
// and the parity helper used by both the transmitter and the receiver.
package uart_pkg;

  localparam int DEFAULT_DATA_BITS  = 8;
  localparam int DEFAULT_FIFO_DEPTH = 4;
  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int DEFAULT_DIV_WIDTH  = 12;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_START  = 5'b00010,
    ST_DATA   = 5'b00100,
    ST_PARITY = 5'b01000,
    ST_STOP   = 5'b10000
  } uart_state_e;

  // Payloads up to 9 bits are zero-extended by the caller; zeros do not change the XOR.
  function automatic logic parity_bit(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_buffered_if.sv
// Host-side and pin-side signals of the buffered UART. The host (or bench)
// uses the master modport, the UART itself uses the slave modport.
interface uart_buffered_if #(
  parameter int DATA_BITS = uart_pkg::DEFAULT_DATA_BITS,
  parameter int DIV_WIDTH = uart_pkg::DEFAULT_DIV_WIDTH
) ();

  logic [DIV_WIDTH-1:0] baud_div;
  logic                 parity_en;
  logic                 parity_odd;
  logic                 two_stop;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_push;
  logic                 tx_full;
  logic                 tx_idle;
  logic                 tx;
  logic                 clear_to_send;
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_pop;
  logic                 request_to_send;
  logic                 rx_overrun;
  logic                 parity_err;
  logic                 frame_err;
  logic                 err_clear;

  modport master (
    output baud_div, parity_en, parity_odd, two_stop, tx_data, tx_push,
           clear_to_send, rx, rx_pop, err_clear,
    input  tx_full, tx_idle, tx, rx_data, rx_valid, request_to_send,
           rx_overrun, parity_err, frame_err
  );

  modport slave (
    input  baud_div, parity_en, parity_odd, two_stop, tx_data, tx_push,
           clear_to_send, rx, rx_pop, err_clear,
    output tx_full, tx_idle, tx, rx_data, rx_valid, request_to_send,
           rx_overrun, parity_err, frame_err
  );

endinterface

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO; full/empty come from the
// registered count, so a push while full is dropped even with a same-cycle pop.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage is cleared on reset so the head reads zero while empty after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_buffered.sv
// FIFO-buffered full-duplex UART: shared oversample tick, TX frame FSM with
// CTS gating at frame start, oversampled RX FSM with false-start rejection.
module uart_buffered
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int DIV_WIDTH  = DEFAULT_DIV_WIDTH
) (
  input logic            clk,
  input logic            rst_n,
  uart_buffered_if.slave bus
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = 4;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SUB_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic [DIV_WIDTH-1:0] tick_cnt;
  logic [DIV_WIDTH-1:0] div_q;
  logic                 tick;

  uart_state_e          tx_state, tx_next;
  logic [SW-1:0]        tx_sub;
  logic [BW-1:0]        tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic [DATA_BITS-1:0] tx_head;
  logic                 tx_empty;
  logic [CW-1:0]        tx_count;
  logic                 tx_bit_end;
  logic                 tx_start_ok;
  logic                 tx_stop_done;
  logic                 tx_load;

  uart_state_e          rx_state, rx_next;
  logic [1:0]           rx_sync;
  logic                 rx_s;
  logic [SW-1:0]        rx_sub;
  logic [BW-1:0]        rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_sample;
  logic                 rx_half;
  logic                 rx_push;
  logic                 rx_full;
  logic                 rx_empty;
  logic [CW-1:0]        rx_count;
  logic                 par_set;
  logic                 frame_set;
  logic                 overrun_set;

  // The divisor is captured at each wrap, so a new baud_div takes effect on the next period.
  assign tick = (tick_cnt == div_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      div_q    <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
      div_q    <= bus.baud_div;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.tx_push),
    .pop   (tx_load),
    .din   (bus.tx_data),
    .head  (tx_head),
    .full  (bus.tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .pop   (bus.rx_pop),
    .din   (rx_shift),
    .head  (bus.rx_data),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  assign bus.tx_idle         = (tx_count == '0) && (tx_state == ST_IDLE);
  assign bus.rx_valid        = !rx_empty;
  assign bus.request_to_send = ((CW'(FIFO_DEPTH) - rx_count) >= CW'(2));

  assign tx_bit_end   = tick && (tx_sub == SUB_LAST);
  assign tx_start_ok  = !tx_empty && !bus.clear_to_send;
  assign tx_stop_done = tx_bit_end && (tx_bit == (bus.two_stop ? BW'(1) : BW'(0)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= ST_IDLE;
    else        tx_state <= tx_next;
  end

  // A finished stop period chains straight into the next start bit when data is waiting.
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      ST_IDLE:   if (tick && tx_start_ok) tx_next = ST_START;
      ST_START:  if (tx_bit_end) tx_next = ST_DATA;
      ST_DATA:   if (tx_bit_end && (tx_bit == BIT_LAST))
                   tx_next = bus.parity_en ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tx_bit_end) tx_next = ST_STOP;
      ST_STOP:   if (tx_stop_done) tx_next = tx_start_ok ? ST_START : ST_IDLE;
      default:   tx_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.tx  = 1'b1;
    tx_load = 1'b0;
    case (tx_state)
      ST_IDLE:   tx_load = tick && tx_start_ok;
      ST_START:  bus.tx  = 1'b0;
      ST_DATA:   bus.tx  = tx_shift[0];
      ST_PARITY: bus.tx  = tx_par;
      ST_STOP:   tx_load = tx_stop_done && tx_start_ok;
      default:   bus.tx  = 1'b1;
    endcase
  end

  // tx_bit counts data bits in DATA and stop periods in STOP; it restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sub   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
    end else if (tx_load) begin
      tx_sub   <= '0;
      tx_bit   <= '0;
      tx_shift <= tx_head;
      tx_par   <= parity_bit(9'(tx_head), bus.parity_odd);
    end else if (tick && (tx_state != ST_IDLE)) begin
      if (tx_sub == SUB_LAST) begin
        tx_sub <= '0;
        if (tx_state == ST_DATA) tx_shift <= tx_shift >> 1;
        tx_bit <= (tx_next != tx_state) ? '0 : tx_bit + 1'b1;
      end else begin
        tx_sub <= tx_sub + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_sync <= 2'b11;
    else        rx_sync <= {rx_sync[0], bus.rx};
  end

  assign rx_s      = rx_sync[1];
  assign rx_sample = tick && (rx_sub == SUB_LAST);
  assign rx_half   = tick && (rx_sub == SUB_HALF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= ST_IDLE;
    else        rx_state <= rx_next;
  end

  // The start bit is re-checked half a bit in; a line that is high again there was a glitch.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      ST_IDLE:   if (tick && !rx_s) rx_next = ST_START;
      ST_START:  if (rx_half) rx_next = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:   if (rx_sample && (rx_bit == BIT_LAST))
                   rx_next = bus.parity_en ? ST_PARITY : ST_STOP;
      ST_PARITY: if (rx_sample) rx_next = ST_STOP;
      ST_STOP:   if (rx_sample) rx_next = ST_IDLE;
      default:   rx_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_push     = 1'b0;
    par_set     = 1'b0;
    frame_set   = 1'b0;
    overrun_set = 1'b0;
    case (rx_state)
      ST_PARITY: par_set = rx_sample && (rx_s != parity_bit(9'(rx_shift), bus.parity_odd));
      ST_STOP: begin
        rx_push     = rx_sample;
        frame_set   = rx_sample && !rx_s;
        overrun_set = rx_sample && rx_full;
      end
      default: rx_push = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sub   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else if (rx_state == ST_IDLE) begin
      rx_sub <= '0;
      rx_bit <= '0;
    end else if (tick) begin
      if ((rx_state == ST_START) && (rx_sub == SUB_HALF)) begin
        rx_sub <= '0;
      end else if (rx_sub == SUB_LAST) begin
        rx_sub <= '0;
        if (rx_state == ST_DATA) rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
        rx_bit <= (rx_next != rx_state) ? '0 : rx_bit + 1'b1;
      end else begin
        rx_sub <= rx_sub + 1'b1;
      end
    end
  end

  // Setting wins over err_clear so an error landing in the clear cycle is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rx_overrun <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.frame_err  <= 1'b0;
    end else begin
      if (overrun_set)        bus.rx_overrun <= 1'b1;
      else if (bus.err_clear) bus.rx_overrun <= 1'b0;
      if (par_set)            bus.parity_err <= 1'b1;
      else if (bus.err_clear) bus.parity_err <= 1'b0;
      if (frame_set)          bus.frame_err  <= 1'b1;
      else if (bus.err_clear) bus.frame_err  <= 1'b0;
    end
  end

endmodule

// File: doc/uart_buffered.md
Name: uart_buffered

Overview:
Parametrised, FIFO-buffered full-duplex UART and the successor to the single-byte UART in the MCU peripheral set.
- Adds configurable data width, optional even/odd parity, 1 or 2 stop bits, 16x-oversampled RX with false-start rejection, TX/RX FIFOs, and sticky error flags.
- Sits behind the MCU peripheral register decoder and drives the tx/rx pins plus RTS/CTS flow control.

Parameters:
DATA_BITS, 8, payload bits per frame (5..9)
FIFO_DEPTH, 4, entries per TX and RX FIFO (power of 2, >=2)
OVERSAMPLE, 16, ticks per bit period (even, >=4)
DIV_WIDTH, 12, width of baud_div

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
baud_div  in  DIV_WIDTH  clk cycles per oversample tick minus 1
parity_en  in  1  1 = parity bit present
parity_odd  in  1  1 = odd parity, 0 = even
two_stop  in  1  1 = TX sends 2 stop bits
tx_data  in  DATA_BITS  byte to enqueue
tx_push  in  1  enqueue tx_data this cycle
tx_full  out  1  TX FIFO full
tx_idle  out  1  TX FIFO empty and TX FSM idle
tx  out  1  serial out, idles high
clear_to_send  in  1  active-low CTS; frame start permitted only while 0
rx  in  1  serial in (asynchronous)
rx_data  out  DATA_BITS  RX FIFO head (first-word fall-through)
rx_valid  out  1  RX FIFO not empty
rx_pop  in  1  dequeue head
request_to_send  out  1  high while RX FIFO has at least 2 free entries
rx_overrun  out  1  sticky: frame dropped, RX FIFO full
parity_err  out  1  sticky: parity mismatch
frame_err  out  1  sticky: stop bit sampled 0
err_clear  in  1  clears all three sticky flags

Behaviour:
- Reset (async, rst_n=0): tx=1, FIFOs empty, FSMs idle, flags 0, tick counter 0.
  - Outputs: tx_full=0, tx_idle=1, rx_valid=0, rx_data=0, request_to_send=1.
  - Reset mid-frame aborts the frame; no partial data is retained.
- Tick generator: free-running counter 0..baud_div. A one-cycle tick pulses when count==baud_div, then the count wraps to 0. A change of baud_div applies on the next wrap.
- Bit period is OVERSAMPLE ticks.
- FIFOs:
  - Push when full is ignored.
  - Pop when empty is ignored.
  - Full is evaluated on the registered count, so a push while full is dropped even if a pop occurs in the same cycle.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE->START on a tick with FIFO non-empty and clear_to_send==0. The head is popped into the shift register in that cycle; tx goes 0 from the next cycle.
  - Each state lasts OVERSAMPLE ticks. DATA shifts LSB first, DATA_BITS bits. PARITY is entered only if parity_en.
  - Parity bit = XOR of data bits, XOR parity_odd.
  - STOP lasts 1 or 2 bit periods per two_stop, then returns to IDLE. Back-to-back frames have no extra gap.
  - CTS is checked only at frame start; deasserting it mid-frame does not abort the frame.
  - Config inputs must be stable while tx_idle=0.
- RX: rx passes through a 2-flop synchroniser, so there are 2 cycles of latency.
- RX FSM states: IDLE, START, DATA, PARITY, STOP. All states act on ticks only.
  - IDLE->START when synced rx==0 on a tick; sub-counter cleared.
  - START: at sub-count OVERSAMPLE/2-1, rx==1 is a false start and returns to IDLE; otherwise the sub-counter restarts.
  - DATA/PARITY/STOP: sample at the bit centre, i.e. every OVERSAMPLE ticks.
  - STOP: only the first stop bit is checked. If it samples 0, set frame_err.
  - On a parity mismatch, set parity_err.
  - Frame completion: the byte is pushed even when it carries errors. If the RX FIFO is full, the byte is dropped and rx_overrun is set. FSM returns to IDLE immediately after the stop sample.
- Sticky flags: set has priority over err_clear in the same cycle.
- request_to_send is combinational from the RX FIFO count.

Decomposition:
- uart_pkg holds:
  - TX/RX state enum (one-hot, 5 states, shared)
  - START/DATA/PARITY/STOP encodings
  - default parameter constants
- Sub-module uart_fifo: synchronous FIFO parametrised by WIDTH and DEPTH, with push, pop, full, empty, count, and head. It is instantiated twice.

Test Plan:
- 8N1: baud_div=0, OVERSAMPLE=16, push 0xA5 -> tx holds 0, 1,0,1,0,0,1,0,1, then 1, each level for 16 clk; tx_idle returns 1 after 160 clk.
- 8E1/8O1 loopback tx->rx: send 0x07 -> parity bit 1 (even) / 0 (odd); rx_data=0x07, rx_valid=1, parity_err=0; force a flipped parity bit -> parity_err=1 until err_clear.
- Depth/overrun: FIFO_DEPTH=4, receive 5 bytes 0x01..0x05 without popping -> rx_overrun=1; pops return 0x01..0x04; request_to_send drops after the 3rd byte.
- False start: rx low pulse of 4 ticks -> no FIFO push, FSM back in IDLE; a following valid 0x3C frame is received correctly.
- Frame error and flow control: send 0x55 with stop bit forced 0 -> frame_err=1, byte still pushed. Separately, hold clear_to_send=1 with 2 bytes queued -> tx stays 1; release -> both frames sent back-to-back.
- Async reset mid-TX frame: tx=1 and tx_idle=1 without waiting for a clock edge; FIFOs empty after reset.
